// File: rtl/triplet_pkg.sv
// ============================================================================
// Module  : triplet_pkg
// Brief   : Shared types and constants for the triplet packer.
// Revision: 1.0
// ============================================================================
`default_nettype none

package triplet_pkg;

    localparam int GROUP_LEN = 3;
    localparam int IDX_W     = 2;

    typedef enum logic [1:0] {
        FILL = 2'd0,
        EVAL = 2'd1,
        OUT  = 2'd2
    } state_t;

    // Mask with a 1 in every group position below 'fill', i.e. the bits that hold data.
    function automatic logic [GROUP_LEN-1:0] keep_mask(input logic [IDX_W-1:0] fill);
        logic [GROUP_LEN-1:0] m;
        for (int i = 0; i < GROUP_LEN; i++) begin
            m[i] = (IDX_W'(i) < fill);
        end
        return m;
    endfunction

endpackage

`default_nettype wire

// File: rtl/triplet_packer_if.sv
// ============================================================================
// Module  : triplet_packer_if
// Brief   : Serial-in, parity-stage and result-handshake signals of the packer.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface triplet_packer_if #(
    parameter int CNT_W = 8
);
    logic             bit_in;
    logic             bit_valid;
    logic             bit_ready;
    logic             flush;
    logic             a_out;
    logic             b_out;
    logic             c_out;
    logic             x_in;
    logic             parity_out;
    logic             parity_valid;
    logic             parity_ready;
    logic [CNT_W-1:0] group_count;

    // Packer side
    modport master (
        input  bit_in, bit_valid, flush, x_in, parity_ready,
        output bit_ready, a_out, b_out, c_out, parity_out, parity_valid, group_count
    );

    // Environment side: serial source, parity stage and result consumer
    modport slave (
        output bit_in, bit_valid, flush, x_in, parity_ready,
        input  bit_ready, a_out, b_out, c_out, parity_out, parity_valid, group_count
    );

endinterface

`default_nettype wire

// File: rtl/triplet_packer.sv
// ============================================================================
// Module  : triplet_packer
// Brief   : Deserialises bits into 3-bit groups for a combinational parity
//           stage and returns its result through a valid/ready handshake.
// Revision: 1.0
// ============================================================================
`default_nettype none

module triplet_packer
    import triplet_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  wire logic         clk,
    input  wire logic         reset,
    triplet_packer_if.master  bus
);

    state_t               r_state;
    logic [IDX_W-1:0]     r_idx;
    logic [GROUP_LEN-1:0] r_grp;
    logic                 r_parity;
    logic                 r_valid;
    logic                 r_ready;
    logic [CNT_W-1:0]     r_count;

    logic                 w_accept;
    logic                 w_last;
    logic [IDX_W-1:0]     w_fill_cnt;
    logic [GROUP_LEN-1:0] w_grp_wr;

    assign w_accept   = r_ready && bus.bit_valid;
    assign w_last     = (r_idx == IDX_W'(GROUP_LEN - 1));
    assign w_fill_cnt = r_idx + IDX_W'(w_accept);

    always_comb begin
        w_grp_wr = r_grp;
        if (w_accept) begin
            w_grp_wr[r_idx] = bus.bit_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= FILL;
            r_idx    <= '0;
            r_grp    <= '0;
            r_parity <= 1'b0;
            r_valid  <= 1'b0;
            r_ready  <= 1'b1;
            r_count  <= '0;
        end else begin
            case (r_state)
                FILL: begin
                    if (w_accept && w_last) begin
                        r_grp   <= w_grp_wr;
                        r_idx   <= '0;
                        r_ready <= 1'b0;
                        r_state <= EVAL;
                    end else if (bus.flush && (w_fill_cnt != '0)) begin
                        // A bit arriving with flush is kept; only the positions after it pad to 0.
                        r_grp   <= w_grp_wr & keep_mask(w_fill_cnt);
                        r_idx   <= '0;
                        r_ready <= 1'b0;
                        r_state <= EVAL;
                    end else if (w_accept) begin
                        r_grp <= w_grp_wr;
                        r_idx <= w_fill_cnt;
                    end
                end
                EVAL: begin
                    // a/b/c have been stable for a full cycle, so X is settled here.
                    r_parity <= bus.x_in;
                    r_count  <= r_count + 1'b1;
                    r_valid  <= 1'b1;
                    r_state  <= OUT;
                end
                OUT: begin
                    if (bus.parity_ready) begin
                        r_grp   <= '0;
                        r_valid <= 1'b0;
                        r_ready <= 1'b1;
                        r_state <= FILL;
                    end
                end
                default: begin
                    r_state <= FILL;
                    r_idx   <= '0;
                    r_grp   <= '0;
                    r_valid <= 1'b0;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign bus.bit_ready    = r_ready;
    assign bus.a_out        = r_grp[0];
    assign bus.b_out        = r_grp[1];
    assign bus.c_out        = r_grp[2];
    assign bus.parity_out   = r_parity;
    assign bus.parity_valid = r_valid;
    assign bus.group_count  = r_count;

endmodule

`default_nettype wire

// File: tb/tb_triplet_packer.sv
// ============================================================================
// Module  : tb_triplet_packer
// Brief   : Self-checking bench: packer plus odd-parity stage, with a
//           narrow-counter twin that shares the same stimulus.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_triplet_packer;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    triplet_packer_if #(.CNT_W(8)) bus  ();
    triplet_packer_if #(.CNT_W(2)) bus2 ();

    // Three-input odd-parity stage next to each packer
    assign bus.x_in  = bus.a_out  ^ bus.b_out  ^ bus.c_out;
    assign bus2.x_in = bus2.a_out ^ bus2.b_out ^ bus2.c_out;

    assign bus2.bit_in       = bus.bit_in;
    assign bus2.bit_valid    = bus.bit_valid;
    assign bus2.flush        = bus.flush;
    assign bus2.parity_ready = bus.parity_ready;

    triplet_packer #(.CNT_W(8)) dut  (.clk(clk), .reset(reset), .bus(bus.master));
    triplet_packer #(.CNT_W(2)) dut2 (.clk(clk), .reset(reset), .bus(bus2.master));

    int tests_run = 0;
    int failures  = 0;
    int model_count;

    function automatic logic [2:0] got_abc();
        return {bus.c_out, bus.b_out, bus.a_out};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.bit_in       = 1'b0;
        bus.bit_valid    = 1'b0;
        bus.flush        = 1'b0;
        bus.parity_ready = 1'b0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        model_count = 0;
    endtask

    // Sends n bits (bits[0] first), closes short groups by flush (with the
    // last bit or on the next cycle), then holds parity_ready low for 'stall' OUT cycles.
    task automatic run_group(input logic [2:0] bits, input int n, input bit flush_last,
                             input int stall, input string tag);
        logic [2:0] exp_grp;
        logic [2:0] part;
        logic       exp_par;
        exp_grp = 3'b000;
        for (int i = 0; i < n; i++) exp_grp[i] = bits[i];
        exp_par = ^exp_grp;

        for (int i = 0; i < n; i++) begin
            tests_run++;
            if (bus.bit_ready !== 1'b1) begin
                failures++;
                $display("FAIL %s bit_ready before bit %0d: got %b want 1", tag, i, bus.bit_ready);
            end
            bus.bit_valid = 1'b1;
            bus.bit_in    = bits[i];
            bus.flush     = (i == n - 1) && flush_last;
            step();
            if (i < n - 1 && !(bus.flush)) begin
                part = exp_grp & 3'((1 << (i + 1)) - 1);
                tests_run++;
                if (got_abc() !== part) begin
                    failures++;
                    $display("FAIL %s partial abc after bit %0d: got %b want %b", tag, i, got_abc(), part);
                end
            end
        end
        if (n < 3 && !flush_last) begin
            bus.bit_valid = 1'b0;
            bus.flush     = 1'b1;
            step();
        end

        // EVAL: inputs that must be ignored are deliberately active
        bus.bit_valid    = 1'b1;
        bus.bit_in       = 1'b1;
        bus.flush        = 1'b1;
        bus.parity_ready = (stall == 0);
        tests_run++;
        if (bus.bit_ready !== 1'b0 || bus.parity_valid !== 1'b0 || got_abc() !== exp_grp) begin
            failures++;
            $display("FAIL %s eval: got ready=%b valid=%b abc=%b want ready=0 valid=0 abc=%b",
                     tag, bus.bit_ready, bus.parity_valid, got_abc(), exp_grp);
        end
        model_count++;
        step();

        for (int s = 0; s <= stall; s++) begin
            tests_run++;
            if (bus.parity_valid !== 1'b1 || bus.parity_out !== exp_par || bus.bit_ready !== 1'b0 ||
                got_abc() !== exp_grp) begin
                failures++;
                $display("FAIL %s out cycle %0d: got valid=%b par=%b ready=%b abc=%b want 1 %b 0 %b",
                         tag, s, bus.parity_valid, bus.parity_out, bus.bit_ready, got_abc(), exp_par, exp_grp);
            end
            tests_run++;
            if (bus.group_count !== 8'(model_count) || bus2.group_count !== 2'(model_count)) begin
                failures++;
                $display("FAIL %s group_count: got %0d/%0d want %0d/%0d", tag, bus.group_count,
                         bus2.group_count, 8'(model_count), 2'(model_count));
            end
            if (s == stall) bus.parity_ready = 1'b1;
            step();
        end
        idle_inputs();

        tests_run++;
        if (bus.parity_valid !== 1'b0 || bus.bit_ready !== 1'b1 || got_abc() !== 3'b000) begin
            failures++;
            $display("FAIL %s after handshake: got valid=%b ready=%b abc=%b want 0 1 000",
                     tag, bus.parity_valid, bus.bit_ready, got_abc());
        end
    endtask

    task automatic test_reset();
        apply_reset();
        step();
        tests_run++;
        if (bus.bit_ready !== 1'b1 || got_abc() !== 3'b000 || bus.parity_out !== 1'b0 ||
            bus.parity_valid !== 1'b0 || bus.group_count !== 8'd0 || bus2.group_count !== 2'd0) begin
            failures++;
            $display("FAIL reset state: got ready=%b abc=%b par=%b valid=%b cnt=%0d",
                     bus.bit_ready, got_abc(), bus.parity_out, bus.parity_valid, bus.group_count);
        end
    endtask

    task automatic test_basic();
        apply_reset();
        run_group(3'b101, 3, 1'b0, 0, "basic_101");
    endtask

    task automatic test_back_to_back();
        apply_reset();
        run_group(3'b100, 3, 1'b0, 0, "b2b_001");
        run_group(3'b111, 3, 1'b0, 0, "b2b_111");
    endtask

    task automatic test_stall();
        apply_reset();
        run_group(3'b011, 3, 1'b0, 4, "stall_110");
    endtask

    task automatic test_flush();
        apply_reset();
        run_group(3'b001, 1, 1'b0, 0, "flush_1");
        run_group(3'b011, 2, 1'b1, 0, "flush_with_bit");
        run_group(3'b110, 3, 1'b1, 0, "flush_on_third");
        // Flush with an empty group must not start an evaluation
        bus.flush = 1'b1;
        step();
        tests_run++;
        if (bus.bit_ready !== 1'b1 || bus.parity_valid !== 1'b0) begin
            failures++;
            $display("FAIL flush_idx0 first: got ready=%b valid=%b want 1 0", bus.bit_ready, bus.parity_valid);
        end
        bus.flush = 1'b0;
        step();
        tests_run++;
        if (bus.bit_ready !== 1'b1 || bus.parity_valid !== 1'b0 || bus.group_count !== 8'(model_count)) begin
            failures++;
            $display("FAIL flush_idx0 later: got ready=%b valid=%b cnt=%0d want 1 0 %0d",
                     bus.bit_ready, bus.parity_valid, bus.group_count, model_count);
        end
    endtask

    task automatic test_wrap();
        apply_reset();
        for (int g = 0; g < 5; g++) begin
            run_group(3'($urandom_range(0, 7)), 3, 1'b0, 0, "wrap");
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        run_group(3'b010, 3, 1'b0, 0, "pre_abort");
        bus.bit_valid = 1'b1;
        bus.bit_in    = 1'b1;
        step();
        step();
        bus.bit_valid = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        model_count = 0;
        tests_run++;
        if (got_abc() !== 3'b000 || bus.parity_valid !== 1'b0 || bus.group_count !== 8'd0 ||
            bus.parity_out !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid state: got abc=%b valid=%b cnt=%0d par=%b want 000 0 0 0",
                     got_abc(), bus.parity_valid, bus.group_count, bus.parity_out);
        end
        for (int k = 0; k < 4; k++) begin
            step();
            tests_run++;
            if (bus.parity_valid !== 1'b0 || bus.bit_ready !== 1'b1) begin
                failures++;
                $display("FAIL reset_mid idle %0d: got valid=%b ready=%b want 0 1", k, bus.parity_valid, bus.bit_ready);
            end
        end
        run_group(3'b110, 3, 1'b0, 0, "post_abort_011");
    endtask

    task automatic test_random();
        apply_reset();
        for (int g = 0; g < 30; g++) begin
            run_group(3'($urandom_range(0, 7)), int'($urandom_range(1, 3)), 1'($urandom_range(0, 1)),
                      int'($urandom_range(0, 3)), "random");
            repeat ($urandom_range(0, 2)) step();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_basic();
        test_back_to_back();
        test_stall();
        test_flush();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/triplet_packer.md
# triplet_packer

Upstream feeder for the three-input odd-parity stage. It deserialises a bit stream into 3-bit groups and drives each group, registered and stable, onto the parity stage's A/B/C inputs. It samples the returned X and presents it downstream with a valid/ready handshake and a running group count. This lets a serial source use the purely combinational parity logic without glitching or losing results.

## Interface
Parameters:
- CNT_W, default 8: width of the group counter.

Ports:
- clk  in  1  sole clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- bit_in  in  1  serial data bit.
- bit_valid  in  1  bit_in is valid this cycle.
- bit_ready  out  1  packer accepts a bit this cycle.
- flush  in  1  close a partial group, zero-padding the missing positions.
- a_out  out  1  group bit 0 (first received); drives parity stage A.
- b_out  out  1  group bit 1; drives parity stage B.
- c_out  out  1  group bit 2; drives parity stage C.
- x_in  in  1  parity stage result X (combinational from a/b/c_out).
- parity_out  out  1  registered parity of the last completed group.
- parity_valid  out  1  parity_out/group_count valid.
- parity_ready  in  1  downstream consumes the result.
- group_count  out  CNT_W  number of groups emitted since reset, including the current one; wraps modulo 2^CNT_W.

## Operation
- States:
  - FILL: bit_ready=1. A bit is accepted when bit_valid&&bit_ready. It goes to position idx (0→a, 1→b, 2→c), then idx increments.
  - Accepting the bit at idx=2 moves to EVAL, and idx returns to 0.
- flush in FILL:
  - With idx>0 and no bit accepted in the same cycle: positions ≥ idx are cleared to 0, then EVAL.
  - With idx==0: ignored.
  - With a bit accepted in the same cycle: the bit is taken first, and flush pads the remaining positions. If that bit completes the group, flush adds nothing.
- EVAL (one cycle): a/b/c_out held stable. x_in is sampled into parity_out at the end of the cycle. group_count increments and the state moves to OUT.
- OUT: parity_valid=1. parity_out, group_count and a/b/c_out are held. On parity_ready, return to FILL. a/b/c_out are cleared to 0 on that transition.
- bit_ready=0 in EVAL and OUT. No input bits are accepted there.
- flush is ignored outside FILL.
- a/b/c_out are registers. Bits update in place during FILL, so a/b/c_out show the partial group. The parity stage output is only qualified in EVAL.

## Timing
- Reset values: state=FILL, idx=0, a/b/c_out=0, parity_out=0, parity_valid=0, group_count=0.
  - bit_ready=1 from the first cycle after reset deasserts.
- Latency:
  - Third bit accepted in cycle t.
  - EVAL is cycle t+1.
  - parity_valid=1 from t+2.
  - Earliest next bit acceptance: the cycle after parity_ready is seen.
- Maximum throughput: one group per 5 cycles (3 FILL + EVAL + OUT with parity_ready already high).
- parity_ready high while parity_valid=0 has no effect. parity_valid stays high across any number of stall cycles.
- group_count wraps from 2^CNT_W−1 to 0 without any flag.
- reset mid-operation:
  - Aborts any partial group or pending result. No parity_valid is emitted for it.
  - Outputs take reset values on the next edge.

## Structure
- Package triplet_pkg:
  - state enum {FILL, EVAL, OUT}
  - localparam GROUP_LEN=3
  - localparam IDX_W=2
- No sub-module. The parity stage is instantiated beside the packer at the next level up, with a/b/c_out→A/B/C and X→x_in. The bench instantiates both.

## Test plan
- Reset, then bits 1,0,1 on consecutive cycles, parity_ready=1 → abc=101, parity_out=0, parity_valid for one cycle at t+2, group_count=1.
- Bits 0,0,1 then 1,1,1 with parity_ready=1 → parity_out 1 then 1, group_count 1 then 2. bit_ready is low during each EVAL/OUT.
- Bits 1,1,0 with parity_ready held 0 for 4 cycles → parity_valid stays 1 with parity_out=0 throughout. A bit_valid=1 on bit_in is not accepted until after the handshake.
- Bit 1 then flush → abc=100, parity_out=1. Flush with idx=0 → no EVAL, bit_ready stays 1.
- CNT_W=2, five full groups → group_count sequence 1,2,3,0,1.
- Reset asserted after two bits accepted → parity_valid never rises for that group. Next bits 0,1,1 → parity_out=0, group_count=1.
